ysyx_23060020_ifu: RTL and testbench

YSYX_23060020_IFU -- requirements
Module: ysyx_23060020_ifu

---
 rtl/ysyx_23060020_ifu.sv | 124 ++++++++++++
 tb/tb_ysyx_23060020_ifu.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060020_ifu.sv
// Instruction fetch unit: issues one AXI-lite-style read at a time, hands the
// returned word to the execute stage, then waits for the next fetch address.
module ysyx_23060020_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_arvalid,
  output logic [31:0] mem_araddr,
  input  logic        mem_arready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  output logic        mem_rready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        next_pc_valid,
  input  logic [31:0] next_pc,
  output logic        fetch_err,
  output logic        halted,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_R,
    OUT,
    WAIT_PC,
    HALT,
    ERR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  // NOTE: every variable gets its hold value first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    fetch_cnt_d = fetch_cnt_q;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        pc_d    = RESET_PC;
      end
      FETCH: begin
        if (mem_arready) state_d = WAIT_R;
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          if (mem_rresp == 2'b00) begin
            inst_d    = mem_rdata;
            inst_pc_d = pc_q;
            state_d   = OUT;
          end else begin
            state_d = ERR;
          end
        end
      end
      OUT: begin
        if (inst_ready) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = (inst_q == EBREAK) ? HALT : WAIT_PC;
        end
      end
      WAIT_PC: begin
        if (next_pc_valid) begin
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = FETCH;
          end else begin
            state_d = ERR;
          end
        end
      end
      HALT:    state_d = HALT;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // All outputs are pure functions of registered state, so none of them can
  // combinationally depend on a handshake input.
  assign mem_arvalid = (state_q == FETCH);
  assign mem_araddr  = pc_q;
  assign mem_rready  = (state_q == WAIT_R);
  assign inst_valid  = (state_q == OUT);
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign fetch_err   = (state_q == ERR);
  assign halted      = (state_q == HALT);
  assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_23060020_ifu.sv
// Randomized self-checking bench for ysyx_23060020_ifu against a transaction-
// level model: expected fetch address, delivered word and accepted count.
module tb_ysyx_23060020_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic [31:0] mem_araddr, mem_rdata;
  logic [1:0]  mem_rresp;
  logic        inst_valid, inst_ready, next_pc_valid;
  logic [31:0] inst, inst_pc, next_pc;
  logic        fetch_err, halted;
  logic [31:0] fetch_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt;

  ysyx_23060020_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
    .mem_rready(mem_rready),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .next_pc_valid(next_pc_valid), .next_pc(next_pc),
    .fetch_err(fetch_err), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // Memory content model: a fixed scramble of the address, never an ebreak.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] w;
    w = (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    if (w == EBREAK) w = w ^ 32'h1;
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
    inst_ready = 1'b0; next_pc_valid = 1'b0; next_pc = '0;
  endtask

  // Leaves the DUT in IDLE with reset released just after a rising edge.
  task automatic do_reset;
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
    exp_cnt = '0;
  endtask

  // One read transaction with the given address-channel and data-channel stalls.
  task automatic do_fetch(input logic [31:0] exp_pc, input int ar_dly, input int r_dly,
                          input logic [1:0] resp, input logic [31:0] data);
    int n;
    n = 0;
    while (!mem_arvalid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (!mem_arvalid || mem_araddr !== exp_pc) begin
      errors++;
      $display("FAIL fetch_req: arvalid=%b araddr=%h, required 1 %h", mem_arvalid, mem_araddr, exp_pc);
    end
    for (int i = 0; i < ar_dly; i++) begin
      mem_arready = 1'b0;
      mem_rvalid  = 1'($urandom);
      mem_rdata   = $urandom;
      tick();
      checks++;
      if ({mem_arvalid, mem_araddr, mem_rready, inst_valid} !== {1'b1, exp_pc, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL ar_stall: arvalid=%b araddr=%h rready=%b ivalid=%b, required 1 %h 0 0",
                 mem_arvalid, mem_araddr, mem_rready, inst_valid, exp_pc);
      end
    end
    mem_arready = 1'b1;
    mem_rvalid  = 1'($urandom);
    tick();
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    checks++;
    if ({mem_arvalid, mem_rready} !== 2'b01) begin
      errors++;
      $display("FAIL wait_r: arvalid=%b rready=%b, required 0 1", mem_arvalid, mem_rready);
    end
    for (int i = 0; i < r_dly; i++) begin
      mem_arready = 1'($urandom);
      tick();
      checks++;
      if ({mem_arvalid, mem_rready, inst_valid} !== 3'b010) begin
        errors++;
        $display("FAIL r_stall: arvalid=%b rready=%b ivalid=%b, required 0 1 0",
                 mem_arvalid, mem_rready, inst_valid);
      end
    end
    mem_arready = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = data;
    mem_rresp   = resp;
    tick();
    mem_rvalid  = 1'b0;
    mem_rdata   = $urandom;
    mem_rresp   = '0;
  endtask

  // Presents the delivered word, holds it for rdy_dly cycles, then accepts it.
  task automatic accept(input logic [31:0] exp_pc, input logic [31:0] data, input int rdy_dly);
    checks++;
    if ({inst_valid, inst, inst_pc, fetch_cnt} !== {1'b1, data, exp_pc, exp_cnt}) begin
      errors++;
      $display("FAIL inst_out: valid=%b inst=%h pc=%h cnt=%h, required 1 %h %h %h",
               inst_valid, inst, inst_pc, fetch_cnt, data, exp_pc, exp_cnt);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      inst_ready    = 1'b0;
      next_pc_valid = 1'($urandom);
      next_pc       = $urandom;
      tick();
      checks++;
      if ({inst_valid, inst, inst_pc, fetch_cnt} !== {1'b1, data, exp_pc, exp_cnt}) begin
        errors++;
        $display("FAIL inst_hold: valid=%b inst=%h pc=%h cnt=%h, required 1 %h %h %h",
                 inst_valid, inst, inst_pc, fetch_cnt, data, exp_pc, exp_cnt);
      end
    end
    inst_ready    = 1'b1;
    next_pc_valid = 1'($urandom);
    next_pc       = $urandom;
    tick();
    inst_ready    = 1'b0;
    next_pc_valid = 1'b0;
    exp_cnt       = exp_cnt + 32'd1;
    checks++;
    if ({inst_valid, fetch_cnt} !== {1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL accept_cnt: valid=%b cnt=%h, required 0 %h", inst_valid, fetch_cnt, exp_cnt);
    end
  endtask

  task automatic give_pc(input logic [31:0] npc, input int dly);
    for (int i = 0; i < dly; i++) begin
      next_pc_valid = 1'b0;
      mem_arready   = 1'($urandom);
      mem_rvalid    = 1'($urandom);
      tick();
      checks++;
      if ({mem_arvalid, mem_rready, inst_valid} !== 3'b000) begin
        errors++;
        $display("FAIL wait_pc: arvalid=%b rready=%b ivalid=%b, required 0 0 0",
                 mem_arvalid, mem_rready, inst_valid);
      end
    end
    mem_arready   = 1'b0;
    mem_rvalid    = 1'b0;
    next_pc_valid = 1'b1;
    next_pc       = npc;
    tick();
    next_pc_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_arready = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      inst_ready = 1'($urandom); next_pc_valid = 1'($urandom); next_pc = $urandom;
      tick();
      checks++;
      if ({mem_arvalid, mem_araddr, mem_rready, inst_valid, inst, inst_pc, fetch_err, halted, fetch_cnt}
          !== {1'b0, RESET_PC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL reset_vals: arv=%b addr=%h rr=%b iv=%b inst=%h pc=%h err=%b halt=%b cnt=%h, required all zero, addr %h",
                 mem_arvalid, mem_araddr, mem_rready, inst_valid, inst, inst_pc, fetch_err, halted, fetch_cnt, RESET_PC);
      end
    end
  endtask

  // Zero-wait memory, cycle-exact: AR in cycle 1, inst_valid in cycle 3.
  task automatic test_basic;
    do_reset();
    tick();
    checks++;
    if ({mem_arvalid, mem_araddr} !== {1'b1, RESET_PC}) begin
      errors++;
      $display("FAIL basic_ar: arvalid=%b araddr=%h, required 1 %h", mem_arvalid, mem_araddr, RESET_PC);
    end
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'h0000_0013;
    tick();
    mem_rvalid  = 1'b0;
    checks++;
    if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0000_0013, RESET_PC}) begin
      errors++;
      $display("FAIL basic_inst: valid=%b inst=%h pc=%h, required 1 00000013 %h", inst_valid, inst, inst_pc, RESET_PC);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready    = 1'b0;
    next_pc_valid = 1'b1;
    next_pc       = 32'h8000_0004;
    tick();
    next_pc_valid = 1'b0;
    checks++;
    if ({mem_arvalid, mem_araddr, fetch_cnt} !== {1'b1, 32'h8000_0004, 32'd1}) begin
      errors++;
      $display("FAIL basic_next: arvalid=%b araddr=%h cnt=%h, required 1 80000004 1", mem_arvalid, mem_araddr, fetch_cnt);
    end
  endtask

  task automatic test_stall;
    do_reset();
    do_fetch(RESET_PC, 5, 2, 2'b00, mem_word(RESET_PC));
    accept(RESET_PC, mem_word(RESET_PC), 4);
  endtask

  task automatic test_random;
    logic [31:0] pc, npc, w;
    do_reset();
    pc = RESET_PC;
    for (int k = 0; k < 40; k++) begin
      w = mem_word(pc);
      do_fetch(pc, $urandom_range(0, 3), $urandom_range(0, 3), 2'b00, w);
      accept(pc, w, $urandom_range(0, 3));
      npc = {$urandom_range(0, 32'h3FFF_FFFF) , 2'b00} ;
      give_pc(npc, $urandom_range(0, 2));
      pc = npc;
    end
  endtask

  task automatic test_halt;
    do_reset();
    do_fetch(RESET_PC, 0, 0, 2'b00, EBREAK);
    accept(RESET_PC, EBREAK, 1);
    checks++;
    if ({halted, fetch_err} !== 2'b10) begin
      errors++;
      $display("FAIL halt_flag: halted=%b err=%b, required 1 0", halted, fetch_err);
    end
    for (int i = 0; i < 5; i++) begin
      next_pc_valid = 1'b1; next_pc = 32'h8000_0010;
      mem_arready = 1'b1; mem_rvalid = 1'b1; inst_ready = 1'b1;
      tick();
      checks++;
      if ({mem_arvalid, mem_rready, inst_valid, halted} !== 4'b0001) begin
        errors++;
        $display("FAIL halt_hold: arv=%b rr=%b iv=%b halt=%b, required 0 0 0 1",
                 mem_arvalid, mem_rready, inst_valid, halted);
      end
    end
    idle_inputs();
  endtask

  task automatic test_misalign;
    do_reset();
    do_fetch(RESET_PC, 0, 0, 2'b00, mem_word(RESET_PC));
    accept(RESET_PC, mem_word(RESET_PC), 0);
    give_pc(32'h8000_0002, 1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({fetch_err, mem_arvalid, mem_rready, inst_valid} !== 4'b1000) begin
        errors++;
        $display("FAIL misalign: err=%b arv=%b rr=%b iv=%b, required 1 0 0 0",
                 fetch_err, mem_arvalid, mem_rready, inst_valid);
      end
      next_pc_valid = 1'b1; next_pc = 32'h8000_0008;
      mem_arready = 1'b1; mem_rvalid = 1'b1;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_rresp;
    do_reset();
    do_fetch(RESET_PC, 1, 1, 2'b10, 32'h0000_0013);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({fetch_err, inst_valid, mem_arvalid, fetch_cnt} !== {3'b100, 32'h0}) begin
        errors++;
        $display("FAIL rresp_err: err=%b iv=%b arv=%b cnt=%h, required 1 0 0 0",
                 fetch_err, inst_valid, mem_arvalid, fetch_cnt);
      end
      mem_rvalid = 1'b1; mem_rresp = 2'b00; inst_ready = 1'b1;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_midtx;
    do_reset();
    do_fetch(RESET_PC, 0, 0, 2'b00, mem_word(RESET_PC));
    accept(RESET_PC, mem_word(RESET_PC), 0);
    give_pc(32'h8000_0040, 0);
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_arvalid, mem_rready, mem_araddr, fetch_cnt} !== {2'b00, RESET_PC, 32'h0}) begin
      errors++;
      $display("FAIL async_rst: arv=%b rr=%b addr=%h cnt=%h, required 0 0 %h 0",
               mem_arvalid, mem_rready, mem_araddr, fetch_cnt, RESET_PC);
    end
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    rst        = 1'b1;
    exp_cnt    = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({mem_arvalid, mem_araddr, mem_rready, inst_valid} !== {1'b1, RESET_PC, 2'b00}) begin
        errors++;
        $display("FAIL stale_r: arv=%b addr=%h rr=%b iv=%b, required 1 %h 0 0",
                 mem_arvalid, mem_araddr, mem_rready, inst_valid, RESET_PC);
      end
    end
    mem_rvalid = 1'b0;
    do_fetch(RESET_PC, 0, 0, 2'b00, mem_word(RESET_PC));
    accept(RESET_PC, mem_word(RESET_PC), 1);
  endtask

  task automatic test_wrap;
    do_reset();
    do_fetch(RESET_PC, 0, 0, 2'b00, mem_word(RESET_PC));
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.fetch_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    accept(RESET_PC, mem_word(RESET_PC), 1);
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_halt();
    test_misalign();
    test_rresp();
    test_reset_midtx();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded 500000 time units");
    $fatal(1);
  end

endmodule
